wb_mem_master: RTL and testbench
================================

Name: wb_mem_master

Overview:
- Single-outstanding Wishbone bus master that turns CPU-side memory requests (valid/ready) into classic Wishbone cycles.
- Sits directly upstream of the SRAM bus slave and any other slaves reached through the bus decoder.
- Handles ack, err and rty terminations, enforces a cycle timeout, and returns a read-data/error response over a valid/ready handshake.

Parameters:
TIMEOUT, 16, max cycles cyc_o may stay high per attempt with no termination before the block self-terminates with error (≥2)
MAX_RETRY, 3, rty_i terminations tolerated per request before reporting error (≥0)

Ports:
clk_bus  in  1  bus clock, all logic on rising edge
rst_bus  in  1  synchronous reset, active-low
req_valid  in  1  CPU request valid
req_ready  out  1  block can accept a request
req_addr  in  32  byte address
req_wdata  in  32  write data
req_be  in  4  byte enables
req_we  in  1  1 = write, 0 = read
resp_valid  out  1  response valid
resp_ready  in  1  CPU accepts response
resp_rdata  out  32  read data (0 for writes and errors)
resp_err  out  1  bus error, retry exhaustion or timeout
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  32  Wishbone address
dat_o  out  32  Wishbone write data
sel_o  out  4  Wishbone byte select
dat_i  in  32  Wishbone read data
ack_i  in  1  slave acknowledge
err_i  in  1  slave error
rty_i  in  1  slave retry

Behaviour:
- Reset (rst_bus==0 at an edge):
  - State goes to IDLE.
  - cyc_o, stb_o, we_o, resp_valid and resp_err are 0; adr_o, dat_o, sel_o and resp_rdata are 0.
  - Retry and timeout counters are cleared.
  - req_ready is 0 while rst_bus is low.
  - Reset mid-cycle drops cyc_o/stb_o on the next edge. The aborted request is discarded and produces no response.
- All Wishbone outputs and resp_* are registered.
- req_ready = (state==IDLE) && rst_bus, combinational.
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE:
  - On req_valid && req_ready, latch addr/wdata/be/we into adr_o/dat_o/sel_o/we_o.
  - Set cyc_o=stb_o=1, clear the retry count and timeout count, then go to BUS.
- BUS: cyc_o=stb_o=1, and adr/dat/sel/we stay stable. Termination is sampled each edge, priority ack_i > err_i > rty_i > timeout:
  - ack_i: resp_rdata = we_o ? 0 : dat_i, resp_err=0.
  - err_i: resp_rdata=0, resp_err=1.
  - ack_i and err_i both end the attempt: cyc_o=stb_o=0, resp_valid=1, go to RESP.
  - rty_i, when retry count < MAX_RETRY: increment the count, cyc_o=stb_o=0, go to BACKOFF.
  - rty_i, when retry count == MAX_RETRY: treat as error.
  - Timeout: the timeout counter increments each BUS cycle without termination. When the count reaches TIMEOUT-1 without termination, treat as error.
- BACKOFF:
  - Exactly one cycle with cyc_o=0.
  - Then reassert cyc_o=stb_o=1 with the same latched fields, reset the timeout count, and return to BUS.
- RESP:
  - resp_valid and resp fields are held until resp_ready is sampled high.
  - Then resp_valid=0 and the state returns to IDLE.
  - The next request is accepted no earlier than the cycle after resp_valid falls.
- Latency against a slave that acks one cycle after seeing cyc&stb:
  - Request accepted at edge N.
  - cyc_o high at N+1.
  - ack_i sampled at N+2.
  - resp_valid high after N+2.
  - Minimum 3-cycle round trip with resp_ready tied high.
- Ack arriving in the same cycle as cyc_o falls is impossible by construction. A stray ack_i/err_i/rty_i in IDLE, BACKOFF or RESP is ignored.

Test Plan:
- Read: req addr=0x0000_0010, we=0, be=4'hF; slave acks at N+2 with dat_i=0xDEAD_BEEF -> cyc_o high exactly 2 cycles, adr_o=0x10, then resp_valid=1, resp_rdata=0xDEADBEEF, resp_err=0.
- Write with backpressure: addr=0x4, wdata=0x1234_5678, be=4'b0011, resp_ready low 4 cycles -> we_o=1, dat_o=0x12345678, sel_o=4'b0011 during BUS; resp_valid held 4 cycles with resp_rdata=0, resp_err=0; req_ready stays 0 until after the handshake.
- Retry: slave returns rty_i twice then ack_i with dat_i=0x0A -> cyc_o drops exactly one cycle twice, adr_o unchanged; resp_rdata=0x0A, resp_err=0. With rty_i four times (MAX_RETRY=3) -> resp_err=1 after the fourth rty.
- Timeout: slave never terminates, TIMEOUT=16 -> cyc_o high exactly 16 cycles, then drops; resp_err=1, resp_rdata=0. Simultaneous ack_i and err_i -> resp_err=0.
- Reset mid-cycle: rst_bus=0 while cyc_o=1 -> next edge cyc_o=0, resp_valid=0, req_ready=0. After rst_bus=1, req_ready=1 and a new read completes normally.

Source files
------------

// File: rtl/wb_mem_master.sv
// Single-outstanding Wishbone classic master: CPU valid/ready request in,
// registered bus cycle with retry/backoff and timeout, valid/ready response out.
module wb_mem_master #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_bus,
    input  logic        rst_bus,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    input  logic        req_we,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    output logic [3:0]  sel_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    input  logic        rty_i
);

    // Counter widths stay at least one bit even for MAX_RETRY==0.
    localparam int RW = $clog2(MAX_RETRY + 2);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          cyc_d, stb_d, we_d, resp_valid_d, resp_err_d;
    logic [31:0]   adr_d, dat_d, resp_rdata_d;
    logic [3:0]    sel_d;

    assign req_ready = (state_q == IDLE) && rst_bus;

    always_ff @(posedge clk_bus) begin
        if (!rst_bus) begin
            state_q    <= IDLE;
            rcnt_q     <= '0;
            tcnt_q     <= '0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            we_o       <= 1'b0;
            adr_o      <= '0;
            dat_o      <= '0;
            sel_o      <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            rcnt_q     <= rcnt_d;
            tcnt_q     <= tcnt_d;
            cyc_o      <= cyc_d;
            stb_o      <= stb_d;
            we_o       <= we_d;
            adr_o      <= adr_d;
            dat_o      <= dat_d;
            sel_o      <= sel_d;
            resp_valid <= resp_valid_d;
            resp_rdata <= resp_rdata_d;
            resp_err   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rcnt_d       = rcnt_q;
        tcnt_d       = tcnt_q;
        cyc_d        = cyc_o;
        stb_d        = stb_o;
        we_d         = we_o;
        adr_d        = adr_o;
        dat_d        = dat_o;
        sel_d        = sel_o;
        resp_valid_d = resp_valid;
        resp_rdata_d = resp_rdata;
        resp_err_d   = resp_err;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    adr_d   = req_addr;
                    dat_d   = req_wdata;
                    sel_d   = req_be;
                    we_d    = req_we;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    rcnt_d  = '0;
                    tcnt_d  = '0;
                    state_d = BUS;
                end
            end
            BUS: begin
                // Termination priority: ack > err > rty > timeout.
                if (ack_i) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = we_o ? 32'h0 : dat_i;
                    resp_err_d   = 1'b0;
                    state_d      = RESP;
                end else if (err_i || (rty_i && rcnt_q == RW'(MAX_RETRY)) ||
                             (!rty_i && tcnt_q == TW'(TIMEOUT - 1))) begin
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 32'h0;
                    resp_err_d   = 1'b1;
                    state_d      = RESP;
                end else if (rty_i) begin
                    rcnt_d  = rcnt_q + 1'b1;
                    cyc_d   = 1'b0;
                    stb_d   = 1'b0;
                    state_d = BACKOFF;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            BACKOFF: begin
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                tcnt_d  = '0;
                state_d = BUS;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_wb_mem_master.sv
// Directed bench for wb_mem_master: a behavioural slave, a driver that checks
// bus-side timing, and a monitor that scores responses against a queue.
module tb_wb_mem_master;

    logic        clk_bus = 1'b0;
    logic        rst_bus;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid, resp_ready, resp_err;
    logic [31:0] resp_rdata;
    logic        cyc_o, stb_o, we_o;
    logic [31:0] adr_o, dat_o, dat_i;
    logic [3:0]  sel_o;
    logic        ack_i, err_i, rty_i;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Slave behaviour knobs
    logic  slv_hang, slv_ack, slv_err;
    int    slv_rty;
    int    rty_done;

    always #5 clk_bus = ~clk_bus;

    wb_mem_master #(.TIMEOUT(16), .MAX_RETRY(3)) dut (
        .clk_bus(clk_bus), .rst_bus(rst_bus),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be), .req_we(req_we),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .sel_o(sel_o), .dat_i(dat_i),
        .ack_i(ack_i), .err_i(err_i), .rty_i(rty_i)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Slave answers one cycle after seeing cyc&stb; first slv_rty answers are retries.
    always @(posedge clk_bus) begin
        ack_i <= 1'b0;
        err_i <= 1'b0;
        rty_i <= 1'b0;
        if (!rst_bus || resp_valid) begin
            rty_done <= 0;
        end else if (cyc_o && stb_o && !ack_i && !err_i && !rty_i && !slv_hang) begin
            if (rty_done < slv_rty) begin
                rty_i    <= 1'b1;
                rty_done <= rty_done + 1;
            end else begin
                ack_i <= slv_ack;
                err_i <= slv_err;
            end
        end
    end

    // Monitor: score every accepted response against the queue.
    always @(negedge clk_bus) begin
        if (rst_bus && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'd1, 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_req(input string name, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic we, input logic [31:0] exp_rdata,
                          input logic exp_err, input int exp_hi, input int exp_lo,
                          input int rr_delay);
        int hi, lo, bad, held, guard;
        hi = 0; lo = 0; bad = 0; held = 0; guard = 0;
        @(negedge clk_bus);
        chk({name, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = addr; req_wdata = wdata; req_be = be; req_we = we;
        exp_q.push_back('{rdata: exp_rdata, err: exp_err});
        @(negedge clk_bus);
        req_valid = 1'b0;
        while (!resp_valid && guard < 200) begin
            if (cyc_o) begin
                hi++;
                if (adr_o !== addr || we_o !== we || sel_o !== be ||
                    (we && dat_o !== wdata) || !stb_o) bad++;
            end else begin
                lo++;
            end
            guard++;
            @(negedge clk_bus);
        end
        chk({name, "_resp_seen"}, {31'd0, resp_valid}, 32'd1);
        chk({name, "_cyc_hi"}, hi, exp_hi);
        chk({name, "_cyc_drop"}, lo, exp_lo);
        chk({name, "_bus_fields"}, bad, 0);
        if (rr_delay > 0) begin
            for (int i = 0; i < rr_delay; i++) begin
                if (resp_valid && !req_ready && resp_rdata === exp_rdata) held++;
                @(negedge clk_bus);
            end
            chk({name, "_held"}, held, rr_delay);
        end
        @(posedge clk_bus); #1;
        resp_ready = 1'b1;
        @(posedge clk_bus); #1;
        resp_ready = 1'b0;
        chk({name, "_valid_drop"}, {31'd0, resp_valid}, 32'd0);
        chk({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        rst_bus = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
        req_be = '0; req_we = 1'b0; resp_ready = 1'b0; dat_i = '0;
        slv_hang = 1'b0; slv_ack = 1'b1; slv_err = 1'b0; slv_rty = 0;
        repeat (3) @(negedge clk_bus);
        chk("rst_cyc", {31'd0, cyc_o}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_adr", adr_o, 32'd0);
        rst_bus = 1'b1;
        @(negedge clk_bus);

        dat_i = 32'hDEAD_BEEF;
        do_req("read", 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 2, 0, 0);
        dat_i = 32'hFFFF_FFFF;
        do_req("write", 32'h4, 32'h1234_5678, 4'b0011, 1'b1, 32'h0, 1'b0, 2, 0, 4);

        dat_i = 32'h0A; slv_rty = 2;
        do_req("retry2", 32'h20, 32'h0, 4'hF, 1'b0, 32'h0A, 1'b0, 6, 2, 0);
        slv_rty = 4;
        do_req("retry4", 32'h24, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 8, 3, 0);
        slv_rty = 0;

        slv_hang = 1'b1;
        do_req("timeout", 32'h28, 32'h0, 4'hF, 1'b0, 32'h0, 1'b1, 16, 0, 0);
        slv_hang = 1'b0;

        slv_err = 1'b1; dat_i = 32'h55;
        do_req("ack_err", 32'h2C, 32'h0, 4'hF, 1'b0, 32'h55, 1'b0, 2, 0, 0);
        slv_ack = 1'b0;
        do_req("err_only", 32'h30, 32'h0, 4'h1, 1'b0, 32'h0, 1'b1, 2, 0, 0);
        slv_ack = 1'b1; slv_err = 1'b0;

        // Reset in the middle of a hung cycle: no response may appear.
        slv_hang = 1'b1;
        @(negedge clk_bus);
        req_valid = 1'b1; req_addr = 32'h40; req_we = 1'b0; req_be = 4'hF;
        @(negedge clk_bus);
        req_valid = 1'b0;
        repeat (2) @(negedge clk_bus);
        chk("mid_cyc_high", {31'd0, cyc_o}, 32'd1);
        rst_bus = 1'b0;
        @(negedge clk_bus);
        chk("mid_rst_cyc", {31'd0, cyc_o}, 32'd0);
        chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("mid_rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst_bus = 1'b1; slv_hang = 1'b0;
        #1;
        chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
        dat_i = 32'hCAFE_0001;
        do_req("post_rst_read", 32'h44, 32'h0, 4'hF, 1'b0, 32'hCAFE_0001, 1'b0, 2, 0, 0);

        repeat (2) @(negedge clk_bus);
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
